// File: rtl/enc_pkg.sv
// Shared constants for the quadrature encoder front end.
//   Q00/Q10/Q11/Q01   : quadrature states, written as {A,B}
//   DECODE_X1/X4      : decode mode selectors
//   ERR_CNT_W         : width of the saturating illegal-transition counter
//   fwd_next()        : next state in the forward direction 00->10->11->01->00
package enc_pkg;

    localparam logic [1:0] Q00 = 2'b00;
    localparam logic [1:0] Q10 = 2'b10;
    localparam logic [1:0] Q11 = 2'b11;
    localparam logic [1:0] Q01 = 2'b01;

    localparam int DECODE_X1 = 1;
    localparam int DECODE_X4 = 4;

    localparam int ERR_CNT_W = 8;

    function automatic logic [1:0] fwd_next(input logic [1:0] q);
        logic [1:0] n;
        case (q)
            Q00:     n = Q10;
            Q10:     n = Q11;
            Q11:     n = Q01;
            default: n = Q00;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/enc_glitch_filter.sv
// One encoder channel: 2-flop synchronizer followed by a persistence filter.
// The filtered level only follows the synchronized input once the two have
// disagreed for FILT_LEN consecutive cycles, so shorter pulses are dropped.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   raw  : asynchronous channel input
//   filt : synchronized, debounced channel level
module enc_glitch_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt
);

    localparam int CW = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            filt  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 != filt) begin
                // Accept on the cycle the count would reach FILT_LEN.
                if (cnt == LAST) begin
                    filt <= sync2;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/quad_encoder_frontend.sv
// Quadrature encoder front end: conditions raw A/B channels and decodes them
// into a step stream with direction, signed position and illegal-transition
// tracking. The ticks level feeds the downstream rpm-measurement stage.
//   CLK, RST    : clock, asynchronous active-high reset
//   enc_a/enc_b : raw asynchronous encoder channels
//   clear       : synchronous position clear (wins over a coincident step)
//   ticks       : toggles on every counted step
//   tick_pulse  : 1-cycle strobe per counted step
//   dir         : 1 = last step forward, 0 = reverse
//   pos         : signed wrapping step count
//   err         : 1-cycle strobe on a both-bits-changed transition
//   err_cnt     : saturating illegal-transition count
module quad_encoder_frontend
    import enc_pkg::*;
#(
    parameter int FILT_LEN = 4,
    parameter int POS_W    = 16,
    parameter int DECODE   = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    enc_a,
    input  logic                    enc_b,
    input  logic                    clear,
    output logic                    ticks,
    output logic                    tick_pulse,
    output logic                    dir,
    output logic signed [POS_W-1:0] pos,
    output logic                    err,
    output logic [ERR_CNT_W-1:0]    err_cnt
);

    localparam int PRIME_N = 2 + FILT_LEN;
    localparam int PW      = $clog2(PRIME_N + 1);
    localparam logic [PW-1:0] PRIME_LAST = PW'(PRIME_N);
    localparam logic signed [POS_W-1:0] ONE = POS_W'(1);

    logic          filt_a;
    logic          filt_b;
    logic [1:0]    cur;
    logic [1:0]    prev;
    logic [PW-1:0] prime_cnt;
    logic          primed;
    logic          step;
    logic          step_fwd;
    logic          illegal;

    enc_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .clk  (CLK),
        .rst  (RST),
        .raw  (enc_a),
        .filt (filt_a)
    );

    enc_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .clk  (CLK),
        .rst  (RST),
        .raw  (enc_b),
        .filt (filt_b)
    );

    assign cur = {filt_a, filt_b};

    // The filters can make their first flip on the cycle the count reaches
    // PRIME_N; primed rises one cycle later so prev has absorbed that flip
    // and an input held non-zero through reset is never seen as a transition.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prime_cnt <= '0;
            primed    <= 1'b0;
            prev      <= Q00;
        end else begin
            prev <= cur;
            if (prime_cnt == PRIME_LAST) begin
                primed <= 1'b1;
            end else begin
                prime_cnt <= prime_cnt + PW'(1);
            end
        end
    end

    always_comb begin
        step     = 1'b0;
        step_fwd = 1'b0;
        illegal  = primed && (cur == ~prev);
        if (DECODE == DECODE_X1) begin
            // A rising with B steady; B low means forward.
            step     = primed && !prev[1] && cur[1] && (cur[0] == prev[0]);
            step_fwd = !cur[0];
        end else begin
            step_fwd = (cur == fwd_next(prev));
            step     = primed && (step_fwd || (prev == fwd_next(cur)));
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ticks      <= 1'b0;
            tick_pulse <= 1'b0;
            dir        <= 1'b0;
            pos        <= '0;
            err        <= 1'b0;
            err_cnt    <= '0;
        end else begin
            tick_pulse <= step;
            err        <= illegal;
            if (step) begin
                ticks <= ~ticks;
                dir   <= step_fwd;
            end
            if (clear) begin
                pos <= '0;
            end else if (step) begin
                pos <= step_fwd ? pos + ONE : pos - ONE;
            end
            if (illegal && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_quad_encoder_frontend.sv
module tb_quad_encoder_frontend;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic enc_a = 1'b0;
    logic enc_b = 1'b0;
    logic clear = 1'b0;

    logic        ticks, tick_pulse, dir, err;
    logic [15:0] pos;
    logic [7:0]  err_cnt;

    logic        ticks4, tick_pulse4, dir4, err4;
    logic [3:0]  pos4;
    logic [7:0]  err_cnt4;

    logic        ticks1, tick_pulse1, dir1, err1;
    logic [15:0] pos1;
    logic [7:0]  err_cnt1;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    int errs   = 0;
    int togs   = 0;
    logic ticks_last = 1'b0;

    always #10 CLK = ~CLK;

    quad_encoder_frontend #(.FILT_LEN(4), .POS_W(16), .DECODE(4)) dut (
        .CLK(CLK), .RST(RST), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
        .ticks(ticks), .tick_pulse(tick_pulse), .dir(dir), .pos(pos),
        .err(err), .err_cnt(err_cnt)
    );

    quad_encoder_frontend #(.FILT_LEN(4), .POS_W(4), .DECODE(4)) dut4 (
        .CLK(CLK), .RST(RST), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
        .ticks(ticks4), .tick_pulse(tick_pulse4), .dir(dir4), .pos(pos4),
        .err(err4), .err_cnt(err_cnt4)
    );

    quad_encoder_frontend #(.FILT_LEN(4), .POS_W(16), .DECODE(1)) dut1 (
        .CLK(CLK), .RST(RST), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
        .ticks(ticks1), .tick_pulse(tick_pulse1), .dir(dir1), .pos(pos1),
        .err(err1), .err_cnt(err_cnt1)
    );

    always @(negedge CLK) begin
        if (tick_pulse) pulses++;
        if (err) errs++;
        if (ticks != ticks_last) togs++;
        ticks_last = ticks;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Change inputs just after an edge, then wait (bounded) for tick_pulse or err.
    task automatic drive_wait(input logic [1:0] ab, output int lat);
        @(posedge CLK); #1;
        {enc_a, enc_b} = ab;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge CLK); #1;
            if (tick_pulse || err) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
    endtask

    task automatic pulse_clear();
        @(posedge CLK); #1; clear = 1'b1;
        @(posedge CLK); #1; clear = 1'b0;
    endtask

    function automatic logic [1:0] fwd(input logic [1:0] q);
        case (q)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] rev(input logic [1:0] q);
        case (q)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    initial begin
        logic [1:0] ab;
        int lat;
        int p0, e0;

        // Reset state
        #1;
        check("rst_async_outputs", {ticks, tick_pulse, dir, pos, err, err_cnt}, 32'd0);
        idle(3); #1;
        RST = 1'b0;
        idle(20); #1;
        check("rst_idle_outputs", {ticks, tick_pulse, dir, pos, err, err_cnt}, 32'd0);
        check("rst_no_pulses", pulses, 0);

        // 1: 8 forward steps, 200 cycles apart
        ab = 2'b00;
        for (int s = 0; s < 8; s++) begin
            ab = fwd(ab);
            drive_wait(ab, lat);
            check($sformatf("t1_latency_%0d", s), lat, 7);
            check($sformatf("t1_pulse_%0d", s), tick_pulse, 1'b1);
            if (s == 0) begin
                @(posedge CLK); #1;
                check("t1_pulse_one_cycle", tick_pulse, 1'b0);
            end
            idle(200 - lat);
        end
        check("t1_pos", pos, 16'd8);
        check("t1_dir", dir, 1'b1);
        check("t1_ticks", ticks, 1'b0);
        check("t1_toggles", togs, 8);
        check("t1_pulses", pulses, 8);

        // 2: clear then 4 reverse steps
        pulse_clear();
        #1;
        check("t2_clear_pos", pos, 16'd0);
        for (int s = 0; s < 4; s++) begin
            ab = rev(ab);
            drive_wait(ab, lat);
            idle(20);
        end
        check("t2_pos", pos, 16'hFFFC);
        check("t2_dir", dir, 1'b0);
        check("t2_err_cnt", err_cnt, 8'd0);

        // 3: 2-cycle glitch on A is dropped; 4-cycle pulse is accepted
        p0 = pulses;
        @(posedge CLK); #1; enc_a = 1'b1;
        idle(2); #1; enc_a = 1'b0;
        idle(30);
        check("t3_glitch_pulses", pulses - p0, 0);
        check("t3_glitch_pos", pos, 16'hFFFC);
        @(posedge CLK); #1; enc_a = 1'b1;
        idle(4); #1; enc_a = 1'b0;
        idle(3); #1;
        check("t3_accept_pulse", tick_pulse, 1'b1);
        check("t3_accept_pos", pos, 16'hFFFD);
        check("t3_accept_dir", dir, 1'b1);
        idle(30); #1;
        check("t3_return_pos", pos, 16'hFFFC);
        check("t3_pulse_count", pulses - p0, 2);

        // 4: both channels toggle together
        ab = 2'b11;
        drive_wait(ab, lat);
        check("t4_err_latency", lat, 7);
        check("t4_err", err, 1'b1);
        check("t4_err_cnt", err_cnt, 8'd1);
        check("t4_pos", pos, 16'hFFFC);
        check("t4_no_pulse", tick_pulse, 1'b0);
        check("t4_ticks", ticks, 1'b0);
        @(posedge CLK); #1;
        check("t4_err_one_cycle", err, 1'b0);
        for (int s = 1; s < 300; s++) begin
            ab = ~ab;
            drive_wait(ab, lat);
            idle(4);
        end
        #1;
        check("t4_err_cnt_sat", err_cnt, 8'd255);
        check("t4_err_events", errs, 300);
        check("t4_pos_after", pos, 16'hFFFC);

        // 5: POS_W=4 wrap, then clear coincident with a step
        pulse_clear();
        ab = 2'b00;
        for (int s = 0; s < 9; s++) begin
            ab = fwd(ab);
            drive_wait(ab, lat);
            idle(15);
        end
        #1;
        check("t5_pos4_wrap", pos4, 4'b1001);
        check("t5_pos16", pos, 16'd9);
        check("t5_x1_pos", pos1, 16'd3);
        ab = fwd(ab);
        @(posedge CLK); #1; {enc_a, enc_b} = ab;
        idle(6); #1; clear = 1'b1;
        @(posedge CLK); #1;
        clear = 1'b0;
        check("t5_clr_step_pulse", tick_pulse4, 1'b1);
        check("t5_clr_step_pos", pos4, 4'd0);
        check("t5_clr_step_dir", dir4, 1'b1);
        check("t5_clr_step_ticks", ticks4, 1'b0);
        check("t5_clr_err_cnt_kept", err_cnt, 8'd255);
        idle(10);

        // 6: reset while inputs sit at 11
        @(posedge CLK); #1; RST = 1'b1;
        #1;
        check("t6_async_rst", {ticks, tick_pulse, dir, pos, err, err_cnt}, 32'd0);
        idle(3); #1; RST = 1'b0;
        p0 = pulses;
        e0 = errs;
        idle(30); #1;
        check("t6_no_pulse", pulses - p0, 0);
        check("t6_no_err", errs - e0, 0);
        check("t6_outputs", {ticks, dir, pos, err_cnt}, 32'd0);
        check("t6_x1_outputs", {ticks1, dir1, pos1, err_cnt1}, 32'd0);

        // X1: 4 full forward cycles from 11
        for (int s = 0; s < 16; s++) begin
            ab = fwd(ab);
            drive_wait(ab, lat);
            idle(15);
        end
        #1;
        check("x1_pos", pos1, 16'd4);
        check("x1_dir", dir1, 1'b1);
        check("x4_pos", pos, 16'd16);
        check("x4_pos4_wrap", pos4, 4'd0);
        check("x1_err_cnt", err_cnt1, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
